// File: rtl/dct_feature_serializer_if.sv
// Feature stream from the DCT serializer to the classifier front-end.
// master = serializer side, slave = consumer side.
interface dct_feature_serializer_if #(
    parameter int ACTIV_BITS = 8,
    parameter int NUM_FRAMES = 49
);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [ACTIV_BITS-1:0] feat_data;
    logic                  feat_valid;
    logic                  feat_ready;
    logic                  feat_first;
    logic                  feat_last;
    logic                  win_last;
    logic [FW-1:0]         frame_idx;

    modport master (
        output feat_data, feat_valid, feat_first, feat_last, win_last, frame_idx,
        input  feat_ready
    );

    modport slave (
        input  feat_data, feat_valid, feat_first, feat_last, win_last, frame_idx,
        output feat_ready
    );
endinterface

// File: rtl/dct_feature_serializer.sv
// Captures packed MFCC DCT vectors into a two-slot ping-pong buffer and
// streams them one coefficient per handshake, tagging frame/window edges.
// Vectors arriving while both slots are held are dropped and flagged.
module dct_feature_serializer #(
    parameter int MFCC_FEATURES = 40,
    parameter int ACTIV_BITS    = 8,
    parameter int NUM_FRAMES    = 49
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [MFCC_FEATURES*ACTIV_BITS-1:0] dct_out,
    input  logic                                dct_valid,
    input  logic [4:0]                          num_mfcc_coeffs,
    input  logic                                ovf_clr,
    output logic                                overflow,
    dct_feature_serializer_if.master            feat
);
    localparam int VW = MFCC_FEATURES * ACTIV_BITS;
    localparam int NW = $clog2(MFCC_FEATURES + 1);
    localparam int FW = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;

    logic [VW-1:0] slot_data [2];
    logic [NW-1:0] slot_n    [2];
    logic [1:0]    slot_full;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [NW-1:0] idx;
    logic [FW-1:0] frame_idx_q;

    logic          rd_valid;
    logic [NW-1:0] cur_n;
    logic          at_last;
    logic          xfer;
    logic          frame_done;
    logic          accept;
    logic          drop;
    logic [NW-1:0] n_eff;
    logic [VW-1:0] rd_vec;

    // Handshake decode, capture decision and clamped coefficient count.
    // When both slots are full the write pointer equals the read pointer,
    // so a capture coinciding with frame completion lands in the slot being freed.
    always_comb begin
        rd_valid   = slot_full[rd_ptr];
        cur_n      = slot_n[rd_ptr];
        at_last    = (idx == cur_n - NW'(1));
        xfer       = rd_valid & feat.feat_ready;
        frame_done = xfer & at_last;
        accept     = dct_valid & (~slot_full[wr_ptr] | frame_done);
        drop       = dct_valid & ~accept;
        if (num_mfcc_coeffs == 5'd0 || 32'(num_mfcc_coeffs) > MFCC_FEATURES)
            n_eff = NW'(MFCC_FEATURES);
        else
            n_eff = NW'(num_mfcc_coeffs);
        rd_vec = slot_data[rd_ptr] >> (32'(idx) * ACTIV_BITS);
    end

    // Output stream: data is forced to zero whenever nothing is presented.
    always_comb begin
        feat.feat_valid = rd_valid;
        feat.feat_data  = rd_valid ? rd_vec[ACTIV_BITS-1:0] : '0;
        feat.feat_first = rd_valid & (idx == '0);
        feat.feat_last  = rd_valid & at_last;
        feat.win_last   = rd_valid & at_last & (frame_idx_q == FW'(NUM_FRAMES - 1));
        feat.frame_idx  = frame_idx_q;
    end

    // Buffer slots: capture on accept, release on frame completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                slot_data[i] <= '0;
                slot_n[i]    <= '0;
            end
            slot_full <= '0;
            wr_ptr    <= 1'b0;
        end else begin
            if (frame_done)
                slot_full[rd_ptr] <= 1'b0;
            if (accept) begin
                slot_data[wr_ptr] <= dct_out;
                slot_n[wr_ptr]    <= n_eff;
                slot_full[wr_ptr] <= 1'b1;
                wr_ptr            <= ~wr_ptr;
            end
        end
    end

    // Read side: coefficient index, read pointer and frame position in window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx         <= '0;
            rd_ptr      <= 1'b0;
            frame_idx_q <= '0;
        end else if (xfer) begin
            if (at_last) begin
                idx    <= '0;
                rd_ptr <= ~rd_ptr;
                if (frame_idx_q == FW'(NUM_FRAMES - 1))
                    frame_idx_q <= '0;
                else
                    frame_idx_q <= frame_idx_q + FW'(1);
            end else begin
                idx <= idx + NW'(1);
            end
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            overflow <= 1'b0;
        else if (drop)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end
endmodule

// File: tb/tb_dct_feature_serializer.sv
// Bench for dct_feature_serializer: queue-based reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_dct_feature_serializer;
    localparam int MF = 40;
    localparam int AB = 8;
    localparam int NF = 3;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [MF*AB-1:0]  dct_out = '0;
    logic              dct_valid = 1'b0;
    logic [4:0]        num = 5'd0;
    logic              ovf_clr = 1'b0;
    logic              overflow;

    dct_feature_serializer_if #(.ACTIV_BITS(AB), .NUM_FRAMES(NF)) ifc ();

    dct_feature_serializer #(.MFCC_FEATURES(MF), .ACTIV_BITS(AB), .NUM_FRAMES(NF)) dut (
        .clk(clk), .rst_n(rst_n), .dct_out(dct_out), .dct_valid(dct_valid),
        .num_mfcc_coeffs(num), .ovf_clr(ovf_clr), .overflow(overflow), .feat(ifc.master)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [AB-1:0] c [MF];
        int            n;
    } vec_t;

    vec_t mq[$];
    int   m_idx = 0;
    int   m_frame = 0;
    bit   m_ovf = 0;

    int   checks = 0;
    int   failures = 0;
    int   n_xfer = 0;
    int   win_at = -1;
    int   win_cnt = 0;
    int   got[$];
    int   fseq[$];

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [MF*AB-1:0] pack(input int base);
        logic [MF*AB-1:0] v;
        v = '0;
        for (int k = 0; k < MF; k++) v[k*AB +: AB] = AB'(base + k);
        return v;
    endfunction

    // Reference model: FIFO of at most two frames, updated on each clock edge.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                mq.delete();
                m_idx = 0;
                m_frame = 0;
                m_ovf = 0;
            end else begin
                bit   drop;
                vec_t v;
                drop = 0;
                if (mq.size() > 0 && ifc.feat_ready) begin
                    if (m_idx == mq[0].n - 1) begin
                        void'(mq.pop_front());
                        m_idx = 0;
                        m_frame = (m_frame + 1) % NF;
                    end else begin
                        m_idx++;
                    end
                end
                if (dct_valid) begin
                    if (mq.size() < 2) begin
                        for (int k = 0; k < MF; k++) v.c[k] = dct_out[k*AB +: AB];
                        v.n = (num == 0 || int'(num) > MF) ? MF : int'(num);
                        mq.push_back(v);
                    end else begin
                        drop = 1;
                    end
                end
                if (drop) m_ovf = 1;
                else if (ovf_clr) m_ovf = 0;
            end
        end
    end

    // Every-cycle comparison against the model and transfer logging.
    initial begin
        forever begin
            @(negedge clk);
            begin
                bit            ev, ef, el;
                logic [AB-1:0] ed;
                ev = (mq.size() > 0);
                ed = ev ? mq[0].c[m_idx] : '0;
                ef = ev && (m_idx == 0);
                el = ev && (m_idx == mq[0].n - 1);
                chk("feat_valid", 64'(ifc.feat_valid), 64'(ev));
                chk("feat_data",  64'(ifc.feat_data),  64'(ed));
                chk("feat_first", 64'(ifc.feat_first), 64'(ef));
                chk("feat_last",  64'(ifc.feat_last),  64'(el));
                chk("win_last",   64'(ifc.win_last),   64'(el && m_frame == NF - 1));
                chk("frame_idx",  64'(ifc.frame_idx),  64'(m_frame));
                chk("overflow",   64'(overflow),       64'(m_ovf));
                if (ifc.feat_valid && ifc.feat_ready) begin
                    n_xfer++;
                    got.push_back(int'(ifc.feat_data));
                    if (ifc.win_last) begin
                        win_at = n_xfer;
                        win_cnt++;
                    end
                    if (ifc.feat_first) fseq.push_back(int'(ifc.frame_idx));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input int base, input int n);
        dct_out   = pack(base);
        num       = 5'(n);
        dct_valid = 1'b1;
        tick();
        dct_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while (mq.size() != 0 && t < 2000) begin
            tick();
            t++;
        end
        if (mq.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL wait_idle: got busy expected idle after %0d cycles", t);
        end
        tick();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int s;
        ifc.feat_ready = 1'b0;
        do_reset();
        chk("rst_valid", 64'(ifc.feat_valid), 64'd0);
        chk("rst_data",  64'(ifc.feat_data),  64'd0);
        chk("rst_frame", 64'(ifc.frame_idx),  64'd0);
        chk("rst_ovf",   64'(overflow),       64'd0);

        // single 13-coefficient vector, ready held high
        ifc.feat_ready = 1'b1;
        s = got.size();
        dct_out = pack(1);
        num = 5'd13;
        dct_valid = 1'b1;
        #1;
        chk("lat_before", 64'(ifc.feat_valid), 64'd0);
        tick();
        dct_valid = 1'b0;
        chk("lat_valid", 64'(ifc.feat_valid), 64'd1);
        chk("lat_data",  64'(ifc.feat_data),  64'd1);
        chk("lat_first", 64'(ifc.feat_first), 64'd1);
        wait_idle();
        chk("t1_count", 64'(got.size() - s), 64'd13);
        for (int k = 0; k < 13; k++) chk("t1_seq", 64'(got[s+k]), 64'(k + 1));

        // backpressure: ready toggles every cycle over a 40-coefficient vector
        s = got.size();
        strobe(8'h40, 0);
        for (int c = 0; c < 200 && mq.size() != 0; c++) begin
            ifc.feat_ready = ~ifc.feat_ready;
            tick();
        end
        ifc.feat_ready = 1'b1;
        wait_idle();
        chk("t2_count", 64'(got.size() - s), 64'd40);
        for (int k = 0; k < 40; k++) chk("t2_seq", 64'(got[s+k]), 64'(8'h40 + k));

        // overflow: three strobes while stalled
        ifc.feat_ready = 1'b0;
        s = got.size();
        strobe(8'h10, 0);
        strobe(8'h60, 0);
        strobe(8'hA0, 0);
        chk("t3_ovf_set", 64'(overflow), 64'd1);
        ifc.feat_ready = 1'b1;
        wait_idle();
        chk("t3_count", 64'(got.size() - s), 64'd80);
        chk("t3_v1_first", 64'(got[s]),      64'h10);
        chk("t3_v1_last",  64'(got[s+39]),   64'h37);
        chk("t3_v2_first", 64'(got[s+40]),   64'h60);
        chk("t3_v2_last",  64'(got[s+79]),   64'h87);
        chk("t3_ovf_hold", 64'(overflow),    64'd1);
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 64'(overflow), 64'd0);

        // simultaneous free and capture with both slots full
        ifc.feat_ready = 1'b0;
        s = got.size();
        strobe(8'h01, 2);
        strobe(8'h11, 2);
        ifc.feat_ready = 1'b1;
        tick();
        dct_out = pack(8'h21);
        num = 5'd2;
        dct_valid = 1'b1;
        tick();
        dct_valid = 1'b0;
        wait_idle();
        chk("t4_ovf",   64'(overflow), 64'd0);
        chk("t4_count", 64'(got.size() - s), 64'd6);
        chk("t4_a",     64'(got[s+1]), 64'h02);
        chk("t4_b",     64'(got[s+2]), 64'h11);
        chk("t4_c0",    64'(got[s+4]), 64'h21);
        chk("t4_c1",    64'(got[s+5]), 64'h22);

        // reset in the middle of a frame
        s = got.size();
        strobe(8'h30, 10);
        for (int c = 0; c < 100 && got.size() < s + 5; c++) tick();
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 64'(ifc.feat_valid), 64'd0);
        chk("t5_rst_data",  64'(ifc.feat_data),  64'd0);
        chk("t5_rst_first", 64'(ifc.feat_first), 64'd0);
        chk("t5_pre_data",  64'(got[s+4]),       64'h34);
        tick();
        rst_n = 1'b1;
        tick();
        strobe(8'h70, 1);
        chk("t5_first", 64'(ifc.feat_first), 64'd1);
        chk("t5_last",  64'(ifc.feat_last),  64'd1);
        chk("t5_data",  64'(ifc.feat_data),  64'h70);
        chk("t5_frame", 64'(ifc.frame_idx),  64'd0);
        wait_idle();

        // window wrap over four 40-coefficient frames
        do_reset();
        fseq.delete();
        s = n_xfer;
        win_cnt = 0;
        for (int f = 0; f < 4; f++) begin
            for (int c = 0; c < 200 && mq.size() >= 2; c++) tick();
            strobe(8'h80 + f, 0);
        end
        wait_idle();
        chk("t6_count",   64'(n_xfer - s), 64'd160);
        chk("t6_win_at",  64'(win_at - s), 64'd120);
        chk("t6_win_cnt", 64'(win_cnt),    64'd1);
        chk("t6_fseq_n",  64'(fseq.size()), 64'd4);
        if (fseq.size() == 4) begin
            chk("t6_f0", 64'(fseq[0]), 64'd0);
            chk("t6_f1", 64'(fseq[1]), 64'd1);
            chk("t6_f2", 64'(fseq[2]), 64'd2);
            chk("t6_f3", 64'(fseq[3]), 64'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #500000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
